// File: rtl/uart_rx_sample_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART RX sample timer.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int DEF_PRESCALE_W = 6;
    localparam int DEF_BIT_CNT_W  = 4;

    localparam int MIN_PRESCALE  = 4;
    localparam int MIN_FRAME_LEN = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rx_state_t;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_sample_timer_majority3.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_majority3
// Description : Three-sample capture register with majority and disagree
//               decode over the two held samples plus the live input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_majority3 (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic capture,
    input  logic rx_in,
    output logic maj,
    output logic disagree
);

    logic [2:0] r_samples;
    logic [2:0] w_window;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samples <= 3'b000;
        end else if (clear) begin
            r_samples <= 3'b000;
        end else if (capture) begin
            r_samples <= {r_samples[1:0], rx_in};
        end
    end

    // Decoding the live input lets the result be registered on the third capture itself.
    assign w_window = {r_samples[1:0], rx_in};
    assign maj      = (w_window[2] & w_window[1]) |
                      (w_window[2] & w_window[0]) |
                      (w_window[1] & w_window[0]);
    assign disagree = (|w_window) & ~(&w_window);

endmodule : uart_rx_majority3
`default_nettype wire

// File: rtl/uart_rx_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sample_timer
// Description : UART RX timing engine - edge/bit counters, frame control and
//               three-point majority sampling around bit centre.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sample_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int BIT_CNT_W  = DEF_BIT_CNT_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_len,
    input  logic                  rx_in,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  busy,
    output logic                  sample_valid,
    output logic                  sampled_bit,
    output logic                  noise_err,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  cfg_err
);

    localparam logic [PRESCALE_W-1:0] c_edge_one     = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  c_bit_one      = BIT_CNT_W'(1);
    localparam logic [PRESCALE_W-1:0] c_min_prescale = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [BIT_CNT_W-1:0]  c_min_frame    = BIT_CNT_W'(MIN_FRAME_LEN);

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    logic [PRESCALE_W-1:0]   r_edge_cnt,     w_edge_nxt;
    logic [BIT_CNT_W-1:0]    r_bit_cnt,      w_bit_nxt;
    logic [PRESCALE_W-1:0]   r_prescale_q,   w_prescale_nxt;
    logic [BIT_CNT_W-1:0]    r_frame_len_q,  w_frame_len_nxt;
    logic                    r_sample_valid, w_sample_valid_nxt;
    logic                    r_sampled_bit,  w_sampled_bit_nxt;
    logic                    r_noise_err,    w_noise_err_nxt;
    logic                    r_bit_done,     w_bit_done_nxt;
    logic                    r_frame_done,   w_frame_done_nxt;
    logic                    r_cfg_err,      w_cfg_err_nxt;

    logic [PRESCALE_W-1:0]   w_half;
    logic                    w_in_window;
    logic                    w_third;
    logic                    w_last_edge;
    logic                    w_last_bit;
    logic                    w_cfg_legal;
    logic                    w_capture;
    logic                    w_sample_clear;
    logic                    w_maj;
    logic                    w_disagree;

    assign w_half      = r_prescale_q >> 1;
    assign w_third     = (r_edge_cnt == (w_half + c_edge_one));
    assign w_in_window = (r_edge_cnt == (w_half - c_edge_one)) ||
                         (r_edge_cnt == w_half) || w_third;
    assign w_last_edge = (r_edge_cnt == (r_prescale_q - c_edge_one));
    assign w_last_bit  = (r_bit_cnt == (r_frame_len_q - c_bit_one));
    assign w_cfg_legal = (prescale >= c_min_prescale) && (frame_len >= c_min_frame);
    assign w_capture   = (r_state == RUN) && enable && !abort && w_in_window;

    uart_rx_majority3 u_majority3 (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (w_sample_clear),
        .capture  (w_capture),
        .rx_in    (rx_in),
        .maj      (w_maj),
        .disagree (w_disagree)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_edge_nxt         = r_edge_cnt;
        w_bit_nxt          = r_bit_cnt;
        w_prescale_nxt     = r_prescale_q;
        w_frame_len_nxt    = r_frame_len_q;
        w_sample_valid_nxt = 1'b0;
        w_sampled_bit_nxt  = r_sampled_bit;
        w_noise_err_nxt    = r_noise_err;
        w_bit_done_nxt     = 1'b0;
        w_frame_done_nxt   = 1'b0;
        w_cfg_err_nxt      = r_cfg_err;
        w_sample_clear     = 1'b0;

        if (abort) begin
            w_state_nxt    = IDLE;
            w_edge_nxt     = '0;
            w_bit_nxt      = '0;
            w_sample_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_edge_nxt = '0;
                    w_bit_nxt  = '0;
                    if (start) begin
                        if (w_cfg_legal) begin
                            w_state_nxt     = RUN;
                            w_prescale_nxt  = prescale;
                            w_frame_len_nxt = frame_len;
                            w_noise_err_nxt = 1'b0;
                            w_cfg_err_nxt   = 1'b0;
                            w_sample_clear  = 1'b1;
                        end else begin
                            w_cfg_err_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // enable low leaves every counter and strobe at its default hold
                    if (enable) begin
                        if (w_third) begin
                            w_sample_valid_nxt = 1'b1;
                            w_sampled_bit_nxt  = w_maj;
                            if (w_disagree) begin
                                w_noise_err_nxt = 1'b1;
                            end
                        end
                        if (w_last_edge) begin
                            w_edge_nxt     = '0;
                            w_bit_done_nxt = 1'b1;
                            if (w_last_bit) begin
                                w_frame_done_nxt = 1'b1;
                                w_bit_nxt        = '0;
                                w_state_nxt      = IDLE;
                            end else begin
                                w_bit_nxt = r_bit_cnt + c_bit_one;
                            end
                        end else begin
                            w_edge_nxt = r_edge_cnt + c_edge_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_edge_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt     <= '0;
            r_bit_cnt      <= '0;
            r_prescale_q   <= '0;
            r_frame_len_q  <= '0;
            r_sample_valid <= 1'b0;
            r_sampled_bit  <= 1'b0;
            r_noise_err    <= 1'b0;
            r_bit_done     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_edge_cnt     <= w_edge_nxt;
            r_bit_cnt      <= w_bit_nxt;
            r_prescale_q   <= w_prescale_nxt;
            r_frame_len_q  <= w_frame_len_nxt;
            r_sample_valid <= w_sample_valid_nxt;
            r_sampled_bit  <= w_sampled_bit_nxt;
            r_noise_err    <= w_noise_err_nxt;
            r_bit_done     <= w_bit_done_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_cfg_err      <= w_cfg_err_nxt;
        end
    end

    assign edge_cnt     = r_edge_cnt;
    assign bit_cnt      = r_bit_cnt;
    assign busy         = (r_state == RUN);
    assign sample_valid = r_sample_valid;
    assign sampled_bit  = r_sampled_bit;
    assign noise_err    = r_noise_err;
    assign bit_done     = r_bit_done;
    assign frame_done   = r_frame_done;
    assign cfg_err      = r_cfg_err;

endmodule : uart_rx_sample_timer
`default_nettype wire

// File: tb/tb_uart_rx_sample_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sample_timer
// Description : Directed self-checking bench for uart_rx_sample_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sample_timer;

    logic       CLK;
    logic       RST;
    logic       start;
    logic       abort;
    logic       enable;
    logic [5:0] prescale;
    logic [3:0] frame_len;
    logic       rx_in;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       sample_valid;
    logic       sampled_bit;
    logic       noise_err;
    logic       bit_done;
    logic       frame_done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    uart_rx_sample_timer #(
        .PRESCALE_W (6),
        .BIT_CNT_W  (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .abort        (abort),
        .enable       (enable),
        .prescale     (prescale),
        .frame_len    (frame_len),
        .rx_in        (rx_in),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .noise_err    (noise_err),
        .bit_done     (bit_done),
        .frame_done   (frame_done),
        .cfg_err      (cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Leaves the bench at the negedge right after the start edge (edge 0 observed).
    task automatic do_start(input logic [5:0] p, input logic [3:0] f);
        @(negedge CLK);
        prescale  = p;
        frame_len = f;
        start     = 1'b1;
        @(negedge CLK);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] all_out;
        RST = 1'b0; start = 1'b0; abort = 1'b0; enable = 1'b1;
        prescale = 6'd8; frame_len = 4'd10; rx_in = 1'b1;
        repeat (2) @(negedge CLK);
        all_out = {edge_cnt, bit_cnt, busy, sample_valid, sampled_bit,
                   noise_err, bit_done, frame_done, cfg_err};
        checks++;
        if (all_out !== 17'd0) begin
            errors++; $display("FAIL reset_initial outputs=%h expected 0", all_out);
        end
        RST = 1'b1;
        do_start(6'd8, 4'd10);
        repeat (20) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        all_out = {edge_cnt, bit_cnt, busy, sample_valid, sampled_bit,
                   noise_err, bit_done, frame_done, cfg_err};
        checks++;
        if (all_out !== 17'd0) begin
            errors++; $display("FAIL reset_midframe outputs=%h expected 0", all_out);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_release busy=%b edge=%0d bit=%0d expected 0/0/0",
                               busy, edge_cnt, bit_cnt);
        end
    endtask

    task automatic test_full_frame();
        int   p_tab [3] = '{8, 7, 4};
        int   f_tab [3] = '{10, 2, 2};
        bit   konst [3] = '{1'b1, 1'b0, 1'b0};
        int   p, f, total;
        logic [5:0] exp_edge;
        logic [3:0] exp_bit;
        logic exp_bd, exp_fd, exp_sv, exp_busy, exp_sb;
        for (int r = 0; r < 3; r++) begin
            p = p_tab[r]; f = f_tab[r]; total = p * f;
            rx_in = 1'b1; enable = 1'b1;
            do_start(6'(p), 4'(f));
            checks++;
            if (busy !== 1'b1 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
                errors++; $display("FAIL frame_start p=%0d busy=%b edge=%0d bit=%0d expected 1/0/0",
                                   p, busy, edge_cnt, bit_cnt);
            end
            rx_in = konst[r] ? 1'b1 : 1'b0;
            for (int cyc = 1; cyc <= total; cyc++) begin
                @(negedge CLK);
                exp_edge = (cyc == total) ? 6'd0 : 6'(cyc % p);
                exp_bit  = (cyc == total) ? 4'd0 : 4'(cyc / p);
                exp_bd   = ((cyc % p) == 0);
                exp_fd   = (cyc == total);
                exp_sv   = ((cyc % p) == ((p / 2 + 2) % p));
                exp_busy = (cyc != total);
                exp_sb   = konst[r] ? 1'b1 : 1'(((cyc - 1) / p) % 2);
                checks++;
                if (edge_cnt !== exp_edge || bit_cnt !== exp_bit || busy !== exp_busy) begin
                    errors++; $display("FAIL frame_cnt p=%0d cyc=%0d edge=%0d bit=%0d busy=%b expected %0d/%0d/%b",
                                       p, cyc, edge_cnt, bit_cnt, busy, exp_edge, exp_bit, exp_busy);
                end
                checks++;
                if (bit_done !== exp_bd || frame_done !== exp_fd || sample_valid !== exp_sv) begin
                    errors++; $display("FAIL frame_strobe p=%0d cyc=%0d bd/fd/sv=%b%b%b expected %b%b%b",
                                       p, cyc, bit_done, frame_done, sample_valid, exp_bd, exp_fd, exp_sv);
                end
                if (exp_sv) begin
                    checks++;
                    if (sampled_bit !== exp_sb) begin
                        errors++; $display("FAIL frame_sample p=%0d cyc=%0d sampled_bit=%b expected %b",
                                           p, cyc, sampled_bit, exp_sb);
                    end
                end
                rx_in = konst[r] ? 1'b1 : 1'((cyc / p) % 2);
            end
            checks++;
            if (noise_err !== 1'b0) begin
                errors++; $display("FAIL frame_noise p=%0d noise_err=%b expected 0", p, noise_err);
            end
        end
    endtask

    task automatic test_noise();
        enable = 1'b1; rx_in = 1'b1;
        do_start(6'd8, 4'd2);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            rx_in = (cyc - 1 == 4) ? 1'b0 : ((cyc - 1) >= 8 ? 1'b0 : 1'b1);
            @(negedge CLK);
            if (cyc == 6) begin
                checks++;
                if (sample_valid !== 1'b1 || sampled_bit !== 1'b1 || noise_err !== 1'b1) begin
                    errors++; $display("FAIL noise_bit0 sv=%b sb=%b ne=%b expected 1/1/1",
                                       sample_valid, sampled_bit, noise_err);
                end
            end
            if (cyc == 14) begin
                checks++;
                if (sample_valid !== 1'b1 || sampled_bit !== 1'b0 || noise_err !== 1'b1) begin
                    errors++; $display("FAIL noise_bit1 sv=%b sb=%b ne=%b expected 1/0/1",
                                       sample_valid, sampled_bit, noise_err);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1 || noise_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL noise_end fd=%b ne=%b busy=%b expected 1/1/0",
                               frame_done, noise_err, busy);
        end
        rx_in = 1'b1;
    endtask

    task automatic test_cfg_err();
        do_start(6'd3, 4'd10);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || noise_err !== 1'b1) begin
            errors++; $display("FAIL cfg_prescale cfg=%b busy=%b ne=%b expected 1/0/1",
                               cfg_err, busy, noise_err);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++;
            if (busy !== 1'b0 || bit_done !== 1'b0 || sample_valid !== 1'b0 || frame_done !== 1'b0) begin
                errors++; $display("FAIL cfg_idle k=%0d busy/bd/sv/fd=%b%b%b%b expected 0000",
                                   k, busy, bit_done, sample_valid, frame_done);
            end
        end
        do_start(6'd8, 4'd1);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL cfg_framelen cfg=%b busy=%b expected 1/0", cfg_err, busy);
        end
        do_start(6'd8, 4'd2);
        checks++;
        if (cfg_err !== 1'b0 || noise_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL cfg_clear cfg=%b ne=%b busy=%b expected 0/0/1",
                               cfg_err, noise_err, busy);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
    endtask

    task automatic test_pause();
        int cyc, nbd, nsv;
        bit paused;
        enable = 1'b1; rx_in = 1'b1;
        do_start(6'd5, 4'd6);
        cyc = 0; nbd = 0; nsv = 0; paused = 1'b0;
        while (frame_done !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (bit_done === 1'b1) nbd++;
            if (sample_valid === 1'b1) nsv++;
            if (!paused && edge_cnt === 6'd2 && bit_cnt === 4'd4) begin
                paused = 1'b1;
                enable = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    cyc++;
                    checks++;
                    if (edge_cnt !== 6'd2 || bit_cnt !== 4'd4 || bit_done !== 1'b0 || sample_valid !== 1'b0) begin
                        errors++; $display("FAIL pause_hold k=%0d edge=%0d bit=%0d bd=%b sv=%b expected 2/4/0/0",
                                           k, edge_cnt, bit_cnt, bit_done, sample_valid);
                    end
                end
                enable = 1'b1;
            end
        end
        checks++;
        if (cyc !== 33) begin
            errors++; $display("FAIL pause_latency frame_done_cycle=%0d expected 33", cyc);
        end
        checks++;
        if (nbd !== 6 || nsv !== 6) begin
            errors++; $display("FAIL pause_counts bit_done=%0d sample_valid=%0d expected 6/6", nbd, nsv);
        end
    endtask

    task automatic test_abort();
        int cyc, nbd, nsv;
        enable = 1'b1; rx_in = 1'b1;
        do_start(6'd8, 4'd10);
        for (cyc = 0; cyc < 43; cyc++) begin
            rx_in = (cyc == 4) ? 1'b0 : 1'b1;
            @(negedge CLK);
        end
        checks++;
        if (edge_cnt !== 6'd3 || bit_cnt !== 4'd5 || noise_err !== 1'b1) begin
            errors++; $display("FAIL abort_pos edge=%0d bit=%0d ne=%b expected 3/5/1",
                               edge_cnt, bit_cnt, noise_err);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0 ||
            frame_done !== 1'b0 || bit_done !== 1'b0 || noise_err !== 1'b1) begin
            errors++; $display("FAIL abort_idle busy=%b edge=%0d bit=%0d fd=%b bd=%b ne=%b expected 0/0/0/0/0/1",
                               busy, edge_cnt, bit_cnt, frame_done, bit_done, noise_err);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++;
            if (busy !== 1'b0 || frame_done !== 1'b0 || bit_done !== 1'b0 || sample_valid !== 1'b0) begin
                errors++; $display("FAIL abort_quiet k=%0d busy/fd/bd/sv=%b%b%b%b expected 0000",
                                   k, busy, frame_done, bit_done, sample_valid);
            end
        end
        do_start(6'd8, 4'd3);
        checks++;
        if (busy !== 1'b1 || noise_err !== 1'b0) begin
            errors++; $display("FAIL abort_restart busy=%b ne=%b expected 1/0", busy, noise_err);
        end
        cyc = 0; nbd = 0; nsv = 0;
        while (frame_done !== 1'b1 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (bit_done === 1'b1) nbd++;
            if (sample_valid === 1'b1) nsv++;
        end
        checks++;
        if (cyc !== 24 || nbd !== 3 || nsv !== 3) begin
            errors++; $display("FAIL abort_refill cycle=%0d bd=%0d sv=%0d expected 24/3/3", cyc, nbd, nsv);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_noise();
        test_cfg_err();
        test_pause();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_sample_timer
`default_nettype wire
